// File: rtl/uart_rx_core.sv
// ============================================================================
// Module   : uart_rx_core
// Purpose  : 16x-oversampling UART receiver (8N1 / 8E1) with valid/ready
//            byte delivery and framing/parity/overrun/break pulses.
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_rx_core #(
    parameter int PARITY_EN = 0,
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rxd,
    input  logic [DIV_WIDTH-1:0] baudDiv,
    output logic [7:0]           dataOut,
    output logic                 dataValid,
    input  logic                 dataReady,
    output logic                 busy,
    output logic                 framingError,
    output logic                 parityError,
    output logic                 overrun,
    output logic                 breakDetect
);

    localparam logic [3:0] c_samp_a   = 4'd7;
    localparam logic [3:0] c_samp_b   = 4'd8;
    localparam logic [3:0] c_samp_dec = 4'd9;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_START    = 3'd1,
        S_DATA     = 3'd2,
        S_PARITY   = 3'd3,
        S_STOP     = 3'd4,
        S_WAITHIGH = 3'd5
    } state_t;

    state_t                r_state;
    logic                  r_sync1;
    logic                  r_rxs;
    logic                  r_rxs_prev;
    logic [DIV_WIDTH-1:0]  r_div_cnt;
    logic [3:0]            r_sample_cnt;
    logic                  r_s7;
    logic                  r_s8;
    logic [2:0]            r_bit_idx;
    logic [7:0]            r_shift;
    logic                  r_par_err;
    logic [7:0]            r_data_out;
    logic                  r_data_valid;
    logic                  r_fe;
    logic                  r_pe;
    logic                  r_ov;
    logic                  r_brk;

    logic w_tick;
    logic w_decide;
    logic w_bit;
    logic w_deliver;

    assign w_tick    = (r_state != S_IDLE) && (r_div_cnt == '0);
    assign w_decide  = w_tick && (r_sample_cnt == c_samp_dec);
    // Bit value is the 2-of-3 vote over samples 7, 8 and the current (9th) one
    assign w_bit     = (r_s7 & r_s8) | (r_s7 & r_rxs) | (r_s8 & r_rxs);
    assign w_deliver = w_decide && (r_state == S_STOP) && w_bit;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_sync1      <= 1'b1;
            r_rxs        <= 1'b1;
            r_rxs_prev   <= 1'b1;
            r_div_cnt    <= '0;
            r_sample_cnt <= 4'd0;
            r_s7         <= 1'b1;
            r_s8         <= 1'b1;
            r_bit_idx    <= 3'd0;
            r_shift      <= 8'd0;
            r_par_err    <= 1'b0;
            r_data_out   <= 8'd0;
            r_data_valid <= 1'b0;
            r_fe         <= 1'b0;
            r_pe         <= 1'b0;
            r_ov         <= 1'b0;
            r_brk        <= 1'b0;
        end else begin
            r_sync1    <= rxd;
            r_rxs      <= r_sync1;
            r_rxs_prev <= r_rxs;

            r_fe  <= 1'b0;
            r_pe  <= 1'b0;
            r_ov  <= 1'b0;
            r_brk <= 1'b0;

            // Holding the reload in IDLE aligns the tick phase to the start edge
            if ((r_state == S_IDLE) || (r_div_cnt == '0))
                r_div_cnt <= baudDiv;
            else
                r_div_cnt <= r_div_cnt - {{(DIV_WIDTH-1){1'b0}}, 1'b1};

            if (w_tick) begin
                r_sample_cnt <= r_sample_cnt + 4'd1;
                if (r_sample_cnt == c_samp_a) r_s7 <= r_rxs;
                if (r_sample_cnt == c_samp_b) r_s8 <= r_rxs;
            end

            // A new byte colliding with an unconsumed one is dropped
            if (w_deliver) begin
                if (r_data_valid && !dataReady) begin
                    r_ov <= 1'b1;
                end else begin
                    r_data_out   <= r_shift;
                    r_data_valid <= 1'b1;
                end
            end else if (dataReady) begin
                r_data_valid <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (r_rxs_prev && !r_rxs) begin
                        r_state      <= S_START;
                        r_sample_cnt <= 4'd0;
                        r_par_err    <= 1'b0;
                    end
                end
                S_START: begin
                    if (w_decide) begin
                        if (w_bit) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_state   <= S_DATA;
                            r_bit_idx <= 3'd0;
                        end
                    end
                end
                S_DATA: begin
                    if (w_decide) begin
                        r_shift[r_bit_idx] <= w_bit;
                        if (r_bit_idx == 3'd7)
                            r_state <= (PARITY_EN != 0) ? S_PARITY : S_STOP;
                        else
                            r_bit_idx <= r_bit_idx + 3'd1;
                    end
                end
                S_PARITY: begin
                    if (w_decide) begin
                        r_par_err <= (w_bit != (^r_shift));
                        r_state   <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (w_decide) begin
                        r_pe <= r_par_err;
                        if (w_bit) begin
                            r_state <= S_IDLE;
                        end else begin
                            if (r_shift == 8'd0) r_brk <= 1'b1;
                            else                 r_fe  <= 1'b1;
                            r_state <= S_WAITHIGH;
                        end
                    end
                end
                S_WAITHIGH: begin
                    if (r_rxs) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign dataOut      = r_data_out;
    assign dataValid    = r_data_valid;
    assign busy         = (r_state != S_IDLE);
    assign framingError = r_fe;
    assign parityError  = r_pe;
    assign overrun      = r_ov;
    assign breakDetect  = r_brk;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_core.sv
// ============================================================================
// Module   : tb_uart_rx_core
// Purpose  : Directed self-checking bench for uart_rx_core (no-parity and
//            even-parity instances).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_uart_rx_core;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] baudDiv = 16'd0;
    logic        dataReady = 1'b1;
    logic        rxd0 = 1'b1;
    logic        rxd1 = 1'b1;

    logic [7:0]  dataOut0, dataOut1;
    logic        dataValid0, dataValid1, busy0, busy1;
    logic        fe0_o, pe0_o, ov0_o, brk0_o;
    logic        fe1_o, pe1_o, ov1_o, brk1_o;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    uart_rx_core #(.PARITY_EN(0), .DIV_WIDTH(16)) dut0 (
        .clk(clk), .reset(reset), .rxd(rxd0), .baudDiv(baudDiv),
        .dataOut(dataOut0), .dataValid(dataValid0), .dataReady(dataReady),
        .busy(busy0), .framingError(fe0_o), .parityError(pe0_o),
        .overrun(ov0_o), .breakDetect(brk0_o)
    );

    uart_rx_core #(.PARITY_EN(1), .DIV_WIDTH(16)) dut1 (
        .clk(clk), .reset(reset), .rxd(rxd1), .baudDiv(baudDiv),
        .dataOut(dataOut1), .dataValid(dataValid1), .dataReady(dataReady),
        .busy(busy1), .framingError(fe1_o), .parityError(pe1_o),
        .overrun(ov1_o), .breakDetect(brk1_o)
    );

    // Observation counters, sampled on the falling edge
    int cyc = 0;
    int nrise0 = 0, rise_cyc0 = 0, vhi0 = 0, fe0 = 0, pe0 = 0, ov0 = 0, brk0 = 0, ov_cyc0 = 0;
    int nrise1 = 0, rise_cyc1 = 0, fe1 = 0, pe1 = 0, pe_cyc1 = 0;
    logic [7:0] rise_data0 = 8'd0, rise_data1 = 8'd0;
    logic pv0 = 1'b0, pv1 = 1'b0;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (dataValid0 && !pv0) begin nrise0++; rise_cyc0 = cyc; rise_data0 = dataOut0; end
        if (dataValid1 && !pv1) begin nrise1++; rise_cyc1 = cyc; rise_data1 = dataOut1; end
        pv0 = dataValid0;
        pv1 = dataValid1;
        if (dataValid0) vhi0++;
        if (fe0_o) fe0++;
        if (pe0_o) pe0++;
        if (ov0_o) begin ov0++; ov_cyc0 = cyc; end
        if (brk0_o) brk0++;
        if (fe1_o) fe1++;
        if (pe1_o) begin pe1++; pe_cyc1 = cyc; end
    end

    task automatic set_rxd(input int sel, input logic v);
        if (sel == 0) rxd0 = v;
        else          rxd1 = v;
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    // Start, 8 data LSB first, parity (instance 1 only), stop; each bit bitclk clocks
    task automatic send_frame(input int sel, input logic [7:0] d, input logic p,
                              input logic s, input int bitclk, output int start_cyc);
        @(negedge clk);
        set_rxd(sel, 1'b0);
        #1 start_cyc = cyc;
        repeat (bitclk) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            set_rxd(sel, d[i]);
            repeat (bitclk) @(negedge clk);
        end
        if (sel == 1) begin
            set_rxd(sel, p);
            repeat (bitclk) @(negedge clk);
        end
        set_rxd(sel, s);
        repeat (bitclk) @(negedge clk);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        settle(4);
        checks++; if (dataOut0 !== 8'h00) begin failures++; $display("FAIL reset_dataOut0: got %h want 00", dataOut0); end
        checks++; if (dataValid0 !== 1'b0) begin failures++; $display("FAIL reset_dataValid0: got %b want 0", dataValid0); end
        checks++; if (busy0 !== 1'b0) begin failures++; $display("FAIL reset_busy0: got %b want 0", busy0); end
        checks++; if ({fe0_o, pe0_o, ov0_o, brk0_o} !== 4'b0000) begin failures++; $display("FAIL reset_pulses0: got %b want 0000", {fe0_o, pe0_o, ov0_o, brk0_o}); end
        checks++; if ({dataOut1, dataValid1, busy1} !== 10'd0) begin failures++; $display("FAIL reset_outs1: got %h want 000", {dataOut1, dataValid1, busy1}); end
        checks++; if ({fe1_o, pe1_o, ov1_o, brk1_o} !== 4'b0000) begin failures++; $display("FAIL reset_pulses1: got %b want 0000", {fe1_o, pe1_o, ov1_o, brk1_o}); end
        @(negedge clk);
        reset = 1'b0;
        settle(3);
    endtask

    task automatic test_good_frame;
        int st, r0, v0, e0;
        baudDiv = 16'd0;
        dataReady = 1'b1;
        r0 = nrise0; v0 = vhi0; e0 = fe0 + pe0 + ov0 + brk0;
        send_frame(0, 8'hA5, 1'b0, 1'b1, 16, st);
        settle(4);
        checks++; if (nrise0 - r0 !== 1) begin failures++; $display("FAIL good_valid_count: got %0d want 1", nrise0 - r0); end
        checks++; if (rise_data0 !== 8'hA5) begin failures++; $display("FAIL good_dataOut: got %h want a5", rise_data0); end
        checks++; if (rise_cyc0 - st !== 157) begin failures++; $display("FAIL good_latency: got %0d want 157", rise_cyc0 - st); end
        checks++; if (vhi0 - v0 !== 1) begin failures++; $display("FAIL good_valid_width: got %0d want 1", vhi0 - v0); end
        checks++; if (fe0 + pe0 + ov0 + brk0 - e0 !== 0) begin failures++; $display("FAIL good_no_errors: got %0d want 0", fe0 + pe0 + ov0 + brk0 - e0); end
        checks++; if (busy0 !== 1'b0) begin failures++; $display("FAIL good_busy_after: got %b want 0", busy0); end
    endtask

    task automatic test_back_to_back;
        int st1, st2, r0, o0;
        dataReady = 1'b0;
        r0 = nrise0; o0 = ov0;
        send_frame(0, 8'h3C, 1'b0, 1'b1, 16, st1);
        send_frame(0, 8'hC3, 1'b0, 1'b1, 16, st2);
        settle(4);
        checks++; if (ov0 - o0 !== 1) begin failures++; $display("FAIL b2b_overrun_count: got %0d want 1", ov0 - o0); end
        checks++; if (ov_cyc0 - st2 !== 157) begin failures++; $display("FAIL b2b_overrun_time: got %0d want 157", ov_cyc0 - st2); end
        checks++; if (dataOut0 !== 8'h3C) begin failures++; $display("FAIL b2b_dataOut_kept: got %h want 3c", dataOut0); end
        checks++; if (dataValid0 !== 1'b1) begin failures++; $display("FAIL b2b_valid_held: got %b want 1", dataValid0); end
        checks++; if (nrise0 - r0 !== 1) begin failures++; $display("FAIL b2b_valid_rises: got %0d want 1", nrise0 - r0); end
        @(negedge clk);
        dataReady = 1'b1;
        settle(1);
        checks++; if (dataValid0 !== 1'b0) begin failures++; $display("FAIL b2b_accept_clears: got %b want 0", dataValid0); end
    endtask

    task automatic test_framing;
        int st, r0, f0, b0;
        dataReady = 1'b1;
        r0 = nrise0; f0 = fe0; b0 = brk0;
        send_frame(0, 8'h55, 1'b0, 1'b0, 16, st);
        settle(20);
        checks++; if (fe0 - f0 !== 1) begin failures++; $display("FAIL frm_fe_count: got %0d want 1", fe0 - f0); end
        checks++; if (brk0 - b0 !== 0) begin failures++; $display("FAIL frm_no_break: got %0d want 0", brk0 - b0); end
        checks++; if (nrise0 - r0 !== 0 || dataValid0 !== 1'b0) begin failures++; $display("FAIL frm_no_delivery: got rises=%0d valid=%b want 0/0", nrise0 - r0, dataValid0); end
        checks++; if (busy0 !== 1'b1) begin failures++; $display("FAIL frm_busy_low_line: got %b want 1", busy0); end
        rxd0 = 1'b1;
        settle(5);
        checks++; if (busy0 !== 1'b0) begin failures++; $display("FAIL frm_busy_released: got %b want 0", busy0); end
    endtask

    task automatic test_break;
        int r0, f0, b0;
        r0 = nrise0; f0 = fe0; b0 = brk0;
        @(negedge clk);
        rxd0 = 1'b0;
        repeat (192) @(negedge clk);
        #1;
        checks++; if (brk0 - b0 !== 1) begin failures++; $display("FAIL brk_count: got %0d want 1", brk0 - b0); end
        checks++; if (fe0 - f0 !== 0) begin failures++; $display("FAIL brk_no_framing: got %0d want 0", fe0 - f0); end
        checks++; if (busy0 !== 1'b1) begin failures++; $display("FAIL brk_busy_waithigh: got %b want 1", busy0); end
        rxd0 = 1'b1;
        settle(40);
        checks++; if (busy0 !== 1'b0 || nrise0 - r0 !== 0) begin failures++; $display("FAIL brk_no_new_frame: got busy=%b rises=%0d want 0/0", busy0, nrise0 - r0); end
    endtask

    task automatic test_glitch;
        int r0, e0;
        r0 = nrise0; e0 = fe0 + pe0 + ov0 + brk0;
        @(negedge clk);
        rxd0 = 1'b0;
        repeat (4) @(negedge clk);
        rxd0 = 1'b1;
        settle(2);
        checks++; if (busy0 !== 1'b1) begin failures++; $display("FAIL glitch_start_seen: got %b want 1", busy0); end
        settle(14);
        checks++; if (busy0 !== 1'b0) begin failures++; $display("FAIL glitch_back_idle: got %b want 0", busy0); end
        checks++; if (nrise0 - r0 !== 0 || fe0 + pe0 + ov0 + brk0 - e0 !== 0) begin failures++; $display("FAIL glitch_no_outputs: got rises=%0d errs=%0d want 0/0", nrise0 - r0, fe0 + pe0 + ov0 + brk0 - e0); end
    endtask

    task automatic test_parity;
        int st, r1, p1, f1;
        baudDiv = 16'd3;
        dataReady = 1'b0;
        r1 = nrise1; p1 = pe1; f1 = fe1;
        send_frame(1, 8'h0F, 1'b1, 1'b1, 64, st);
        settle(4);
        checks++; if (pe1 - p1 !== 1) begin failures++; $display("FAIL par_pe_count: got %0d want 1", pe1 - p1); end
        checks++; if (nrise1 - r1 !== 1 || rise_data1 !== 8'h0F) begin failures++; $display("FAIL par_delivered: got rises=%0d data=%h want 1/0f", nrise1 - r1, rise_data1); end
        checks++; if (rise_cyc1 - st !== 683) begin failures++; $display("FAIL par_latency: got %0d want 683", rise_cyc1 - st); end
        checks++; if (pe_cyc1 !== rise_cyc1) begin failures++; $display("FAIL par_pulse_align: got %0d want %0d", pe_cyc1, rise_cyc1); end
        checks++; if (fe1 - f1 !== 0) begin failures++; $display("FAIL par_no_framing: got %0d want 0", fe1 - f1); end
    endtask

    task automatic test_reset_mid_frame;
        @(negedge clk);
        rxd1 = 1'b0;
        repeat (256) @(negedge clk);
        #1;
        checks++; if (busy1 !== 1'b1 || dataValid1 !== 1'b1) begin failures++; $display("FAIL rst_mid_pre: got busy=%b valid=%b want 1/1", busy1, dataValid1); end
        @(negedge clk);
        reset = 1'b1;
        rxd1 = 1'b1;
        settle(1);
        checks++; if ({dataOut1, dataValid1, busy1} !== 10'd0) begin failures++; $display("FAIL rst_mid_outs: got %h want 000", {dataOut1, dataValid1, busy1}); end
        checks++; if ({fe1_o, pe1_o, ov1_o, brk1_o} !== 4'b0000) begin failures++; $display("FAIL rst_mid_pulses: got %b want 0000", {fe1_o, pe1_o, ov1_o, brk1_o}); end
        @(negedge clk);
        reset = 1'b0;
        settle(10);
        checks++; if (busy1 !== 1'b0 || dataValid1 !== 1'b0) begin failures++; $display("FAIL rst_mid_after: got busy=%b valid=%b want 0/0", busy1, dataValid1); end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_back_to_back();
        test_framing();
        test_break();
        test_glitch();
        test_parity();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
